// File: rtl/sar_adc_pkg.sv
// Shared definitions for the SAR ADC controller.
//   state_t            : controller state encoding (IDLE, SETTLE, DECIDE, DONE)
//   DEF_N_BITS         : default conversion resolution
//   DEF_SETTLE_CYCLES  : default DAC/comparator settle cycles per bit trial
//   SETTLE_CNT_W       : width of the settle counter
//   AVG_COUNT          : conversions per start when SAR_AVG_EN is defined
//   AVG_CNT_W          : width of the conversion counter in averaging mode
package sar_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_N_BITS        = 10;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int SETTLE_CNT_W      = 8;
    localparam int AVG_COUNT         = 4;
    localparam int AVG_CNT_W         = $clog2(AVG_COUNT);

endpackage

// File: rtl/cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (two clock cycles of delay)
module cmp_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller driving an external DAC and
// reading a comparator.  One bit trial = SETTLE_CYCLES settle cycles plus
// one DECIDE cycle, MSB first, so a conversion takes N_BITS*(SETTLE_CYCLES+1)
// cycles from the start-accept edge to result_valid.
//
// Optional feature: macro SAR_AVG_EN runs AVG_COUNT back-to-back conversions
// per start and reports their truncated mean.
//
// Handshake: start is sampled only in IDLE.  result_valid stays high with a
// stable result until result_ready is seen high at a clock edge; that edge
// retires the result and returns to IDLE.  Nothing is queued.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   start        : conversion request (IDLE only)
//   cmp          : asynchronous comparator, 1 = Vin >= Vdac
//   dac_d        : trial code to the DAC, 0 outside a conversion
//   busy         : conversion in progress
//   result       : converted code, held until the next load
//   result_valid : result available
//   result_ready : consumer accepts result
//   fsm_state    : controller state, for observation
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int N_BITS        = DEF_N_BITS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cmp,
    output logic [N_BITS-1:0] dac_d,
    output logic              busy,
    output logic [N_BITS-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output state_t            fsm_state
);

    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    logic cmp_s;

    cmp_sync u_cmp_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cmp),
        .q     (cmp_s)
    );

    state_t                  state, state_n;
    logic [N_BITS-1:0]       sar, sar_n;
    logic [N_BITS-1:0]       result_q, result_n;
    logic [N_BITS-1:0]       trial_bit;
    logic [N_BITS-1:0]       sar_dec;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [SETTLE_CNT_W-1:0] cnt, cnt_n;
`ifdef SAR_AVG_EN
    logic [N_BITS+1:0]       acc, acc_n, acc_sum;
    logic [AVG_CNT_W-1:0]    conv, conv_n;
`endif

    // Bit under trial; dac_d is the decided upper bits plus this trial bit.
    assign trial_bit    = N_BITS'(1) << idx;
    assign busy         = (state == ST_SETTLE) || (state == ST_DECIDE);
    assign dac_d        = busy ? (sar | trial_bit) : '0;
    assign result_valid = (state == ST_DONE);
    assign result       = result_q;
    assign fsm_state    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            sar      <= '0;
            result_q <= '0;
            idx      <= '0;
            cnt      <= '0;
`ifdef SAR_AVG_EN
            acc      <= '0;
            conv     <= '0;
`endif
        end else begin
            state    <= state_n;
            sar      <= sar_n;
            result_q <= result_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
`ifdef SAR_AVG_EN
            acc      <= acc_n;
            conv     <= conv_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        sar_n    = sar;
        result_n = result_q;
        idx_n    = idx;
        cnt_n    = cnt;
        // Trial bit kept if the comparator says Vin >= Vdac.
        sar_dec  = cmp_s ? (sar | trial_bit) : sar;
`ifdef SAR_AVG_EN
        acc_n    = acc;
        conv_n   = conv;
        acc_sum  = acc + (N_BITS + 2)'(sar_dec);
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_SETTLE;
                    sar_n   = '0;
                    idx_n   = IDX_W'(N_BITS - 1);
                    cnt_n   = '0;
`ifdef SAR_AVG_EN
                    acc_n   = '0;
                    conv_n  = '0;
`endif
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_n = ST_DECIDE;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt + 1'b1;
                end
            end
            ST_DECIDE: begin
                sar_n = sar_dec;
                if (idx != '0) begin
                    idx_n   = idx - 1'b1;
                    state_n = ST_SETTLE;
                end else begin
`ifdef SAR_AVG_EN
                    if (conv == AVG_CNT_W'(AVG_COUNT - 1)) begin
                        result_n = acc_sum[N_BITS+1:2];
                        state_n  = ST_DONE;
                    end else begin
                        // Chain straight into the next conversion.
                        acc_n   = acc_sum;
                        conv_n  = conv + 1'b1;
                        sar_n   = '0;
                        idx_n   = IDX_W'(N_BITS - 1);
                        state_n = ST_SETTLE;
                    end
`else
                    result_n = sar_dec;
                    state_n  = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Testbench for sar_adc_ctrl: ideal comparator cmp = (vin >= dac_d),
// scoreboard of expected results checked by an independent monitor.
module tb_sar_adc_ctrl;
    import sar_adc_pkg::*;

    localparam int NB       = 10;
    localparam int SC       = 4;
    localparam int CONV_LAT = NB * (SC + 1);
`ifdef SAR_AVG_EN
    localparam int NCONV    = 4;
`else
    localparam int NCONV    = 1;
`endif
    localparam int LAT      = NCONV * CONV_LAT;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          result_ready = 1'b1;
    logic [NB-1:0] vin = '0;
    logic          cmp;
    logic [NB-1:0] dac_d;
    logic          busy;
    logic [NB-1:0] result;
    logic          result_valid;
    state_t        fsm_state;

    always #5 clk = ~clk;

    assign cmp = (vin >= dac_d);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sar_adc_ctrl #(.N_BITS(NB), .SETTLE_CYCLES(SC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cmp          (cmp),
        .dac_d        (dac_d),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard ----------------
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] vs_arr[4];
    int            accept_cycle = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: an ideal SAR converter returns the input code; with
    // averaging it returns the truncated mean of the per-conversion inputs.
    function automatic logic [NB-1:0] model_result();
        int s = 0;
        for (int k = 0; k < NCONV; k++) s += int'(vs_arr[k]);
        return NB'(s / NCONV);
    endfunction

    // Monitor: on every rising result_valid pop and compare.
    initial begin
        logic prev = 1'b0;
        logic [NB-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (result_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got result 0x%0h expected no result", result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e));
                    check("latency", 32'(cyc - accept_cycle), 32'(LAT));
                    check("busy_at_valid", 32'(busy), 32'(0));
                end
            end
            prev = result_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_vs(input logic [NB-1:0] a, b, c, d);
        vs_arr[0] = a;
        vs_arr[1] = b;
        vs_arr[2] = c;
        vs_arr[3] = d;
    endtask

    // One start; vin follows vs_arr per conversion. stray_at > 0 pulses
    // start at that cycle offset; reset_at > 0 aborts with reset there.
    task automatic do_conv(input int stray_at, input int reset_at);
        bit seen = 1'b0;
        bit aborted = 1'b0;
        int rel;
        vin = vs_arr[0];
        exp_q.push_back(model_result());
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        accept_cycle = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'(1));
        for (int i = 0; i < LAT + 10 && !seen && !aborted; i++) begin
            @(posedge clk);
            #1;
            rel = cyc - accept_cycle;
            if (rel > 0 && rel % CONV_LAT == 0 && rel / CONV_LAT < NCONV)
                vin = vs_arr[rel / CONV_LAT];
            start = (stray_at > 0 && rel == stray_at);
            if (reset_at > 0 && rel == reset_at) begin
                #2;
                reset = 1'b1;
                #1;
                check("rst_dac_d", 32'(dac_d), 32'(0));
                check("rst_busy", 32'(busy), 32'(0));
                check("rst_valid", 32'(result_valid), 32'(0));
                check("rst_result", 32'(result), 32'(0));
                check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
                void'(exp_q.pop_back());
                aborted = 1'b1;
            end
            seen = result_valid;
        end
        start = 1'b0;
        if (!aborted) check("valid_timeout", 32'(seen), 32'(1));
    endtask

    task automatic check_idle_next();
        @(posedge clk);
        #1;
        check("idle_state", 32'(fsm_state), 32'(ST_IDLE));
        check("idle_dac_d", 32'(dac_d), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NB-1:0] held;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dac_d", 32'(dac_d), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_valid", 32'(result_valid), 32'(0));
        check("reset_result", 32'(result), 32'(0));
        check("reset_state", 32'(fsm_state), 32'(ST_IDLE));

        // First start right at reset release; mid-scale pattern.
        result_ready = 1'b1;
        set_vs(10'h2A5, 10'h2A5, 10'h2A5, 10'h2A5);
        do_conv(0, 0);
        check_idle_next();

        // Range extremes.
        set_vs(10'h000, 10'h000, 10'h000, 10'h000);
        do_conv(0, 0);
        check_idle_next();
        set_vs(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
        do_conv(0, 0);
        check_idle_next();

        // Stray starts during conversion and during DONE; result held.
        result_ready = 1'b0;
        set_vs(10'h155, 10'h155, 10'h155, 10'h155);
        held = model_result();
        do_conv(10, 0);
        for (int i = 0; i < 20; i++) begin
            start = (i == 3);
            @(posedge clk);
            #1;
            check("hold_valid", 32'(result_valid), 32'(1));
            check("hold_result", 32'(result), 32'(held));
        end
        start = 1'b0;
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        check("retire_valid", 32'(result_valid), 32'(0));
        check("retire_state", 32'(fsm_state), 32'(ST_IDLE));
        check("retire_result_hold", 32'(result), 32'(held));

        // Reset mid-conversion, then a clean conversion.
        set_vs(10'h0F0, 10'h0F0, 10'h0F0, 10'h0F0);
        do_conv(0, 25);
        set_vs(10'h1C3, 10'h1C3, 10'h1C3, 10'h1C3);
        do_conv(0, 0);
        check_idle_next();

        // Stepped input across the conversions of one start.
        set_vs(10'h100, 10'h101, 10'h102, 10'h103);
        do_conv(0, 0);
        check_idle_next();

        // Randomized inputs with occasional stray starts.
        for (int t = 0; t < 12; t++) begin
            set_vs(NB'($urandom_range(0, 1023)), NB'($urandom_range(0, 1023)),
                   NB'($urandom_range(0, 1023)), NB'($urandom_range(0, 1023)));
            do_conv(($urandom_range(0, 1) == 1) ? $urandom_range(1, LAT - 1) : 0, 0);
            check_idle_next();
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL provide parameter N_BITS, default 10: conversion resolution; sets the width of dac_d and result.
REQ-002 SHALL provide parameter SETTLE_CYCLES, default 4, minimum 3: DAC/comparator settle cycles per bit trial.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  conversion request; sampled only in IDLE.
REQ-006 SHALL have port cmp  input  1  asynchronous comparator output; 1 = Vin >= Vdac.
REQ-007 SHALL have port dac_d  output  N_BITS  trial code driven to the avsddac D input.
REQ-008 SHALL have port busy  output  1  high from start acceptance until result_valid asserts.
REQ-009 SHALL have port result  output  N_BITS  converted code; stable while result_valid = 1.
REQ-010 SHALL have port result_valid  output  1  result available to the core.
REQ-011 SHALL have port result_ready  input  1  core accepts result.

Function
REQ-012 SHALL implement the states IDLE, SETTLE, DECIDE and DONE.
REQ-013 IDLE with start = 1 SHALL go to SETTLE at that edge, set busy = 1, load sar = 0, bit index = N_BITS-1, and drive dac_d = 1 << (N_BITS-1).
REQ-014 SETTLE SHALL hold dac_d for exactly SETTLE_CYCLES cycles, then go to DECIDE.
REQ-015 DECIDE SHALL sample synchronized cmp for one cycle: 1 keeps the trial bit, 0 clears it.
REQ-016 After DECIDE, if bit index > 0 the block SHALL decrement the index, set the next lower bit in dac_d and return to SETTLE; if index = 0 it SHALL go to DONE.
REQ-017 Entry into DONE SHALL load result = final sar, set result_valid = 1 and set busy = 0.
REQ-018 Latency SHALL be N_BITS*(SETTLE_CYCLES+1) cycles from the start-accept edge to result_valid high (50 cycles at defaults).
REQ-019 cmp SHALL pass through a 2-flop synchronizer before use; the 2-cycle sync delay is covered by SETTLE_CYCLES >= 3.
REQ-020 In DONE with result_ready = 1, result_valid SHALL drop at the next edge and the state SHALL return to IDLE; result SHALL hold its value until the next load.
REQ-021 start SHALL be ignored in SETTLE, DECIDE and DONE; there is no queuing and no overflow.
REQ-022 dac_d SHALL be driven to 0 in IDLE and in DONE.
REQ-023 start and result_ready arriving together in DONE SHALL retire the result only; start SHALL NOT be accepted until IDLE.

Reset
REQ-024 Asserting reset at any time, including mid-conversion, SHALL immediately force state = IDLE, dac_d = 0, busy = 0, result = 0, result_valid = 0, the synchronizer flops = 0 and all counters = 0.
REQ-025 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-026 With macro SAR_AVG_EN defined, each accepted start SHALL run 4 back-to-back conversions into an (N_BITS+2)-bit accumulator.
REQ-027 In that mode, result SHALL be acc[N_BITS+1:2] (truncating divide by 4), the latency SHALL be 4x that of REQ-018, and busy SHALL stay high across all 4 conversions.
REQ-028 Without SAR_AVG_EN, the block SHALL perform a single conversion per start and SHALL contain no accumulator logic.

Structure
REQ-029 Package sar_adc_pkg SHALL hold the state enum, the default N_BITS/SETTLE_CYCLES constants, the settle-counter width constant and the average count (4).
REQ-030 The cmp synchronizer SHALL be sub-module cmp_sync (2-flop, async active-high reset); all other logic stays in sar_adc_ctrl.

Verification
REQ-031 Bench SHALL model cmp = (vin >= dac_d). Defaults, vin = 0x2A5, start pulse -> result = 0x2A5 with result_valid rising exactly 50 cycles after the accept edge, and busy low from that edge.
REQ-032 vin = 0x000 -> result 0x000; vin = 0x3FF -> result 0x3FF; dac_d = 0 in IDLE afterward.
REQ-033 start pulsed at cycle 10 of a conversion and again while DONE with result_ready = 0 -> both ignored; result_valid held 20 cycles; result unchanged; ready pulse -> IDLE after 1 edge.
REQ-034 reset asserted at cycle 25 of a conversion -> dac_d, busy, result_valid = 0 without waiting for a clock edge; a new start after release converts correctly.
REQ-035 With SAR_AVG_EN defined, vin stepped 0x100, 0x101, 0x102, 0x103 per conversion -> result = 0x101 after 200 cycles.
